afifo_rd_stream: RTL and testbench

Read-side drain stage placed directly downstream of the asynchronous FIFO, running entirely in the read clock domain. It issues `Pop` only when the FIFO is non-empty and local buffer space is guaranteed, captures the registered `DataOut` one cycle later, and presents the words to the downstream consumer as a valid/ready stream through a 2-entry output buffer. `Pop` is never asserted while `empty` is high, and words are delivered in FIFO order with no loss or duplication.

---
 rtl/afifo_rd_stream_pkg.sv | 13 +
 rtl/afifo_rd_stream_if.sv | 24 ++
 rtl/afifo_rd_stream_buf.sv | 62 ++++++
 rtl/afifo_rd_stream.sv | 69 ++++++
 tb/tb_afifo_rd_stream.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/afifo_rd_stream_pkg.sv
// rtl/afifo_rd_stream_pkg.sv - shared constants and types for the async FIFO read-side drain stage
package afifo_pkg;

    // Output buffer entries; the buffer logic is written for exactly two.
    localparam int AFIFO_BUF_DEPTH = 2;

    // Width of the optional delivered-word counter.
    localparam int AFIFO_CNT_W = 16;

    // Buffer occupancy, 0..2.
    typedef logic [1:0] afifo_occ_t;

endpackage

// File: rtl/afifo_rd_stream_if.sv
// rtl/afifo_rd_stream_if.sv - valid/ready output stream between the drain stage and its consumer
interface afifo_rd_stream_if #(
    parameter int DataSize = 3
);

    logic                OutValid;
    logic [DataSize-1:0] OutData;
    logic                OutReady;

    // The drain stage produces words.
    modport master (
        output OutValid,
        output OutData,
        input  OutReady
    );

    // The consumer accepts words.
    modport slave (
        input  OutValid,
        input  OutData,
        output OutReady
    );

endinterface

// File: rtl/afifo_rd_stream_buf.sv
// rtl/afifo_rd_stream_buf.sv - 2-entry ordered buffer (afifo_rd_buf) with write, accept, head data and occupancy
module afifo_rd_buf
    import afifo_pkg::*;
#(
    parameter int DataSize = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic [DataSize-1:0] wr_data,
    input  logic                acc,
    output logic [DataSize-1:0] head_data,
    output afifo_occ_t          occ
);

    logic [DataSize-1:0] head_q;
    logic [DataSize-1:0] tail_q;

    // Head/tail update; the issuer guarantees no write into a full buffer
    // unless the head is accepted on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (occ)
                2'd0: begin
                    if (wr) begin
                        head_q <= wr_data;
                        occ    <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({wr, acc})
                        2'b10: begin
                            tail_q <= wr_data;
                            occ    <= 2'd2;
                        end
                        // Captured word replaces the departing head directly.
                        2'b11: head_q <= wr_data;
                        2'b01: occ    <= 2'd0;
                        default: ;
                    endcase
                end
                default: begin
                    if (acc) begin
                        head_q <= tail_q;
                        if (wr) begin
                            tail_q <= wr_data;
                        end else begin
                            occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign head_data = head_q;

endmodule

// File: rtl/afifo_rd_stream.sv
// rtl/afifo_rd_stream.sv - async FIFO read-side drain stage; AFIFO_RD_CNT_EN adds the WordCount port
module afifo_rd_stream
    import afifo_pkg::*;
#(
    parameter int DataSize = 3,
    parameter int BufDepth = AFIFO_BUF_DEPTH
) (
    input  logic                   Rclk,
    input  logic                   Rreset,
    input  logic                   empty,
    input  logic [DataSize-1:0]    DataOut,
    output logic                   Pop,
    input  logic                   Stop,
    afifo_rd_stream_if.master      strm
`ifdef AFIFO_RD_CNT_EN
    ,
    output logic [AFIFO_CNT_W-1:0] WordCount
`endif
);

    logic       in_flight;
    logic       acc;
    logic [2:0] load;
    afifo_occ_t occ;

    assign acc = strm.OutValid && strm.OutReady;

    // Issue a pop only when the word it returns is sure to find a buffer slot,
    // counting the word already in flight and the one leaving this edge.
    always_comb begin
        load = {1'b0, occ} + {2'b00, in_flight} - {2'b00, acc};
        Pop  = !Rreset && !Stop && !empty && (load < 3'(BufDepth));
    end

    // A pop sampled on this edge returns data during the next cycle.
    always_ff @(posedge Rclk) begin
        if (Rreset) begin
            in_flight <= 1'b0;
        end else begin
            in_flight <= Pop;
        end
    end

    afifo_rd_buf #(
        .DataSize (DataSize)
    ) u_buf (
        .clk       (Rclk),
        .rst       (Rreset),
        .wr        (in_flight),
        .wr_data   (DataOut),
        .acc       (acc),
        .head_data (strm.OutData),
        .occ       (occ)
    );

    assign strm.OutValid = (occ != 2'd0);

`ifdef AFIFO_RD_CNT_EN
    // Delivered-word counter, wraps naturally at its width.
    always_ff @(posedge Rclk) begin
        if (Rreset) begin
            WordCount <= '0;
        end else if (acc) begin
            WordCount <= WordCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_afifo_rd_stream.sv
// tb/tb_afifo_rd_stream.sv - directed self-checking bench for afifo_rd_stream
module tb_afifo_rd_stream;

    localparam int DW = 3;

    logic          Rclk = 1'b0;
    logic          Rreset;
    logic          empty;
    logic [DW-1:0] DataOut;
    logic          Pop;
    logic          Stop;
`ifdef AFIFO_RD_CNT_EN
    logic [15:0]   WordCount;
`endif

    afifo_rd_stream_if #(.DataSize(DW)) sif ();

    afifo_rd_stream #(
        .DataSize (DW),
        .BufDepth (2)
    ) dut (
        .Rclk      (Rclk),
        .Rreset    (Rreset),
        .empty     (empty),
        .DataOut   (DataOut),
        .Pop       (Pop),
        .Stop      (Stop),
        .strm      (sif.master)
`ifdef AFIFO_RD_CNT_EN
        ,
        .WordCount (WordCount)
`endif
    );

    always #5 Rclk = ~Rclk;

    int            passed = 0;
    int            total  = 0;
    int            viol   = 0;
    logic [DW-1:0] fq[$];
    logic          s_pop;
    logic          s_valid;
    logic          s_acc;
    logic [DW-1:0] s_data;
    logic [15:0]   s_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        empty = 1'b0;
    endtask

    // Sample the current cycle at negedge, then advance past the next posedge
    // and model the FIFO's registered read.
    task automatic step();
        @(negedge Rclk);
        s_pop   = Pop;
        s_valid = sif.OutValid;
        s_data  = sif.OutData;
        s_acc   = sif.OutValid && sif.OutReady;
`ifdef AFIFO_RD_CNT_EN
        s_cnt   = WordCount;
`else
        s_cnt   = 16'h0;
`endif
        if (Pop && empty) viol++;
        @(posedge Rclk);
        #1;
        if (s_pop) begin
            if (fq.size() > 0) DataOut = fq.pop_front();
            else viol++;
        end
        empty = (fq.size() == 0);
    endtask

    task automatic cyc(input string tag, input logic ep, input logic ev, input logic [DW-1:0] ed);
        step();
        chk({tag, "_pop"}, 32'(s_pop), 32'(ep));
        chk({tag, "_valid"}, 32'(s_valid), 32'(ev));
        if (ev) chk({tag, "_data"}, 32'(s_data), 32'(ed));
    endtask

    initial begin
        int got;
        Rreset       = 1'b1;
        Stop         = 1'b0;
        DataOut      = '0;
        sif.OutReady = 1'b1;
        push(3'd5); push(3'd6); push(3'd7);

        // Reset with a non-empty FIFO
        cyc("rst0", 1'b0, 1'b0, 3'd0);
        cyc("rst1", 1'b0, 1'b0, 3'd0);
        cyc("rst2", 1'b0, 1'b0, 3'd0);
        chk("rst_data", 32'(s_data), 32'd0);
`ifdef AFIFO_RD_CNT_EN
        chk("rst_cnt", 32'(s_cnt), 32'd0);
`endif
        Rreset = 1'b0;

        // Streaming 5,6,7
        cyc("str0", 1'b1, 1'b0, 3'd0);
        cyc("str1", 1'b1, 1'b0, 3'd0);
        cyc("str2", 1'b1, 1'b1, 3'd5);
        cyc("str3", 1'b0, 1'b1, 3'd6);
        cyc("str4", 1'b0, 1'b1, 3'd7);
        cyc("str5", 1'b0, 1'b0, 3'd0);

        // Backpressure: only two pops, head held
        sif.OutReady = 1'b0;
        for (int i = 1; i <= 5; i++) push(3'(i));
        cyc("bp0", 1'b1, 1'b0, 3'd0);
        cyc("bp1", 1'b1, 1'b0, 3'd0);
        cyc("bp2", 1'b0, 1'b1, 3'd1);
        cyc("bp3", 1'b0, 1'b1, 3'd1);
        cyc("bp4", 1'b0, 1'b1, 3'd1);
        cyc("bp5", 1'b0, 1'b1, 3'd1);

        // Release: pop reasserts immediately, 1..5 back to back
        sif.OutReady = 1'b1;
        cyc("rel0", 1'b1, 1'b1, 3'd1);
        cyc("rel1", 1'b1, 1'b1, 3'd2);
        cyc("rel2", 1'b1, 1'b1, 3'd3);
        cyc("rel3", 1'b0, 1'b1, 3'd4);
        cyc("rel4", 1'b0, 1'b1, 3'd5);
        cyc("rel5", 1'b0, 1'b0, 3'd0);

        // Stop while a word is in flight
        push(3'd2); push(3'd3); push(3'd4);
        cyc("stp0", 1'b1, 1'b0, 3'd0);
        Stop = 1'b1;
        cyc("stp1", 1'b0, 1'b0, 3'd0);
        cyc("stp2", 1'b0, 1'b1, 3'd2);
        cyc("stp3", 1'b0, 1'b0, 3'd0);
        Stop = 1'b0;
        cyc("stp4", 1'b1, 1'b0, 3'd0);
        cyc("stp5", 1'b1, 1'b0, 3'd0);
        cyc("stp6", 1'b0, 1'b1, 3'd3);
        cyc("stp7", 1'b0, 1'b1, 3'd4);
        cyc("stp8", 1'b0, 1'b0, 3'd0);

        // Reset right after a pop: word 6 is dropped, 3 comes next
        push(3'd6); push(3'd3);
        cyc("mrst0", 1'b1, 1'b0, 3'd0);
        Rreset = 1'b1;
        cyc("mrst1", 1'b0, 1'b0, 3'd0);
        Rreset = 1'b0;
        cyc("mrst2", 1'b1, 1'b0, 3'd0);
        cyc("mrst3", 1'b0, 1'b0, 3'd0);
        cyc("mrst4", 1'b0, 1'b1, 3'd3);
        cyc("mrst5", 1'b0, 1'b0, 3'd0);
`ifdef AFIFO_RD_CNT_EN
        chk("mrst_cnt", 32'(s_cnt), 32'd1);
`endif

        chk("pop_empty", 32'(viol), 32'd0);

`ifdef AFIFO_RD_CNT_EN
        // Counter: three words with OutReady toggling
        Rreset = 1'b1;
        step();
        Rreset = 1'b0;
        push(3'd1); push(3'd2); push(3'd3);
        got = 0;
        for (int i = 0; i < 40 && got < 3; i++) begin
            sif.OutReady = i[0];
            step();
            if (s_acc) begin
                chk("cnt_tog_data", 32'(s_data), 32'(got + 1));
                got++;
            end
        end
        chk("cnt_tog_got", 32'(got), 32'd3);
        sif.OutReady = 1'b1;
        step();
        chk("cnt_3", 32'(s_cnt), 32'd3);

        // Counter: run up to 0xFFFF, then wrap
        for (int i = 0; i < 65532; i++) push(3'(i));
        for (int i = 0; i < 70000 && got < 65535; i++) begin
            step();
            if (s_acc) got++;
        end
        chk("cnt_ffff_got", 32'(got), 32'd65535);
        step();
        chk("cnt_ffff", 32'(s_cnt), 32'h0000_ffff);
        push(3'd7);
        for (int i = 0; i < 20 && got < 65536; i++) begin
            step();
            if (s_acc) got++;
        end
        step();
        chk("cnt_wrap", 32'(s_cnt), 32'd0);
        chk("cnt_pop_empty", 32'(viol), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
